branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//   Next-PC select controller and direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
//   Sits in fetch, directly upstream of the next-PC 4:1 mux, and drives its pc_sel, predicted_target and corr_pc4 inputs.
//   Predicts on the fetch PC every cycle and is trained by branches resolved in execute.
//   An execute-stage misprediction overrides the prediction and raises flush.
// PARAMETERS
//   ENTRIES     16  BTB entries; power of 2
//   INDEX_BITS  4   log2(ENTRIES)
//   TAG_BITS    (30-INDEX_BITS) derived localparam; tag = pc[31:INDEX_BITS+2]
// PORTS
//   clk               in   1   clock; all state updates on posedge
//   rst               in   1   synchronous, active-high reset
//   fetch_pc          in   32  PC currently being fetched (word aligned)
//   ex_valid          in   1   execute stage holds a resolved branch/jump this cycle
//   ex_pc             in   32  PC of the resolved branch
//   ex_taken          in   1   actual direction
//   ex_target         in   32  actual taken target
//   ex_pred_taken     in   1   prediction that travelled down the pipe with this branch
//   ex_pred_target    in   32  predicted target that travelled with it
//   pc_sel            out  3   `PCMUX_* code from defines.vh
//   predicted_target  out  32  BTB target for fetch_pc
//   corr_pc4          out  32  ex_pc + 4 (recovery path for predicted-taken/actually-not-taken)
//   pred_taken        out  1   prediction for fetch_pc; carried down the pipe
//   flush             out  1   squash younger fetched instructions this cycle
//   mispredict_count  out  32  saturating count of mispredictions since reset
// BEHAVIOUR
//   Table: per entry valid(1), tag(TAG_BITS), target(32), ctr(2). Index = pc[INDEX_BITS+1:2].
//   Lookup (combinational from registered table):
//     - hit = valid[idx] && tag[idx]==fetch_pc tag.
//     - pred_taken = hit && ctr[idx][1].
//     - predicted_target = target[idx] when hit, else 0.
//   Mispredict (combinational, ex_valid only):
//     - mis_nt  = ex_pred_taken && !ex_taken
//     - mis_tk  = ex_taken && (!ex_pred_taken || ex_pred_target != ex_target)
//   pc_sel priority:
//     1. rst -> PCMUX_CURR_PC4
//     2. mis_tk -> PCMUX_BRANCH (mux branch input = ex_target externally)
//     3. mis_nt -> PCMUX_CORR_PC4
//     4. pred_taken -> PCMUX_PRED_TGT
//     5. else -> PCMUX_CURR_PC4
//   flush = mis_tk | mis_nt, same cycle; 0 during rst.
//     - pred_taken is forced 0 while flush=1 (that fetch is squashed).
//   corr_pc4 = ex_pc + 32'd4, mod 2^32 (0xFFFFFFFC wraps to 0).
//   Update, posedge clk when ex_valid && !rst; visible to lookup next cycle:
//     - Hit, taken: ctr+1 saturating at 2'b11; target <= ex_target.
//     - Hit, not taken: ctr-1 saturating at 2'b00; target unchanged.
//     - Miss, taken: allocate/replace entry: valid=1, tag, target=ex_target, ctr=2'b10.
//     - Miss, not taken: no change.
//   Same-index lookup and update in one cycle: lookup uses pre-update contents.
//   mispredict_count increments by 1 when flush=1; saturates at 0xFFFFFFFF.
//   Reset (sync): all valid=0, ctr=2'b01, tag/target=0, mispredict_count=0.
//     - Outputs during rst: pc_sel=CURR_PC4, flush=0, pred_taken=0, predicted_target=0.
//     - Asserting rst mid-training discards all entries; first cycle after rst predicts not-taken.
// TESTING
//   1. After rst, fetch_pc=0x100, no ex activity -> pc_sel=CURR_PC4, pred_taken=0, flush=0.
//   2. Train taken miss ex_pc=0x100 -> 0x200, then fetch 0x100 -> pc_sel=PRED_TGT,
//      predicted_target=0x200, pred_taken=1.
//   3. ex_pc=0x100, pred_taken=1, actual not-taken -> pc_sel=CORR_PC4, corr_pc4=0x104,
//      flush=1, count=1; ctr 10->01, next fetch 0x100 predicts not-taken.
//   4. Hit with ex_pred_target=0x200, actual target 0x300 -> pc_sel=BRANCH, flush=1;
//      next lookup of 0x100 gives 0x300.
//   5. Four taken updates on 0x100: ctr saturates at 11; then one not-taken -> 10, still predicts taken.
//   6. Aliasing: 0x140 (same idx, ENTRIES=16) taken replaces 0x100 entry;
//      mid-run rst -> all lookups miss; ex_pc=0xFFFFFFFC gives corr_pc4=0.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - next-PC select and direct-mapped BTB with 2-bit counters
module branch_predictor #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [2:0]  pc_sel,
    output logic [31:0] predicted_target,
    output logic [31:0] corr_pc4,
    output logic        pred_taken,
    output logic        flush,
    output logic [31:0] mispredict_count
);
    localparam int TAG_BITS = 30 - INDEX_BITS;

    localparam logic [2:0] PCMUX_CURR_PC4 = 3'd0;
    localparam logic [2:0] PCMUX_BRANCH   = 3'd1;
    localparam logic [2:0] PCMUX_CORR_PC4 = 3'd2;
    localparam logic [2:0] PCMUX_PRED_TGT = 3'd3;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx, e_idx;
    logic [TAG_BITS-1:0]   f_tag, e_tag;
    logic                  f_hit, e_hit, mis_nt, mis_tk;

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign f_tag = fetch_pc[31:INDEX_BITS+2];
    assign e_idx = ex_pc[INDEX_BITS+1:2];
    assign e_tag = ex_pc[31:INDEX_BITS+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign mis_nt = ex_valid && ex_pred_taken && !ex_taken;
    assign mis_tk = ex_valid && ex_taken && (!ex_pred_taken || (ex_pred_target != ex_target));

    assign corr_pc4 = ex_pc + 32'd4;

    always_comb begin
        pc_sel           = PCMUX_CURR_PC4;
        flush            = 1'b0;
        pred_taken       = 1'b0;
        predicted_target = 32'd0;
        if (!rst) begin
            flush            = mis_tk || mis_nt;
            // a fetch squashed by a redirect must not carry a taken prediction
            pred_taken       = f_hit && ctr_q[f_idx][1] && !flush;
            predicted_target = f_hit ? target_q[f_idx] : 32'd0;
            if (mis_tk)
                pc_sel = PCMUX_BRANCH;
            else if (mis_nt)
                pc_sel = PCMUX_CORR_PC4;
            else if (pred_taken)
                pc_sel = PCMUX_PRED_TGT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_valid) begin
            if (e_hit) begin
                if (ex_taken) begin
                    if (ctr_q[e_idx] != 2'b11)
                        ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
                    target_q[e_idx] <= ex_target;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= ex_target;
                ctr_q[e_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            mispredict_count <= 32'd0;
        else if (flush && (mispredict_count != 32'hFFFF_FFFF))
            mispredict_count <= mispredict_count + 32'd1;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;
    localparam logic [2:0] CURR = 3'd0;
    localparam logic [2:0] BR   = 3'd1;
    localparam logic [2:0] CORR = 3'd2;
    localparam logic [2:0] PRED = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [2:0]  pc_sel;
    logic [31:0] predicted_target;
    logic [31:0] corr_pc4;
    logic        pred_taken;
    logic        flush;
    logic [31:0] mispredict_count;

    typedef struct {
        logic [2:0]  sel;
        logic        pt;
        logic        fl;
        logic [31:0] tgt;
        logic        chk_corr;
        logic [31:0] corr;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .pc_sel           (pc_sel),
        .predicted_target (predicted_target),
        .corr_pc4         (corr_pc4),
        .pred_taken       (pred_taken),
        .flush            (flush),
        .mispredict_count (mispredict_count)
    );

    task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "pc_sel", {29'd0, pc_sel}, {29'd0, e.sel});
            cmp(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
            cmp(e.name, "flush", {31'd0, flush}, {31'd0, e.fl});
            cmp(e.name, "predicted_target", predicted_target, e.tgt);
            cmp(e.name, "mispredict_count", mispredict_count, e.cnt);
            if (e.chk_corr)
                cmp(e.name, "corr_pc4", corr_pc4, e.corr);
        end
    end

    task automatic drive(input logic r, input logic [31:0] fpc, input logic v, input logic [31:0] epc,
                         input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        rst = r; fetch_pc = fpc; ex_valid = v; ex_pc = epc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic expect_out(input string name, input logic [2:0] sel, input logic pt, input logic fl,
                              input logic [31:0] tgt, input logic cc, input logic [31:0] corr,
                              input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.sel = sel; e.pt = pt; e.fl = fl; e.tgt = tgt;
        e.chk_corr = cc; e.corr = corr; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
        next_cycle();
        // second reset cycle: count register now cleared
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("reset", CURR, 0, 0, 32'h0, 0, 0, 0);
        next_cycle();

        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("idle_after_rst", CURR, 0, 0, 32'h0, 0, 0, 0);
        next_cycle();

        drive(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        expect_out("train_miss_taken", BR, 0, 1, 32'h0, 1, 32'h104, 0);
        next_cycle();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("predict_0x200", PRED, 1, 0, 32'h200, 0, 0, 1);
        next_cycle();

        drive(0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        expect_out("mis_not_taken", CORR, 0, 1, 32'h200, 1, 32'h104, 1);
        next_cycle();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("ctr_01_not_taken", CURR, 0, 0, 32'h200, 0, 0, 2);
        next_cycle();

        drive(0, 32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h200);
        expect_out("wrong_target", BR, 0, 1, 32'h200, 0, 0, 2);
        next_cycle();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("new_target_0x300", PRED, 1, 0, 32'h300, 0, 0, 3);
        next_cycle();

        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h300);
            expect_out("taken_correct", PRED, 1, 0, 32'h300, 0, 0, 3);
            next_cycle();
        end
        drive(0, 32'h100, 1, 32'h100, 0, 32'h0, 0, 32'h0);
        expect_out("nt_from_11", PRED, 1, 0, 32'h300, 0, 0, 3);
        next_cycle();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("ctr_10_still_taken", PRED, 1, 0, 32'h300, 0, 0, 3);
        next_cycle();
        drive(0, 32'h100, 1, 32'h100, 0, 32'h0, 0, 32'h0);
        expect_out("nt_from_10", PRED, 1, 0, 32'h300, 0, 0, 3);
        next_cycle();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("ctr_01_nt", CURR, 0, 0, 32'h300, 0, 0, 3);
        next_cycle();

        drive(0, 32'h100, 1, 32'h140, 1, 32'h500, 0, 32'h0);
        expect_out("alias_alloc", BR, 0, 1, 32'h300, 1, 32'h144, 3);
        next_cycle();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        expect_out("alias_evicted", CURR, 0, 0, 32'h0, 0, 0, 4);
        next_cycle();
        drive(0, 32'h140, 0, 0, 0, 0, 0, 0);
        expect_out("alias_hit", PRED, 1, 0, 32'h500, 0, 0, 4);
        next_cycle();

        drive(1, 32'h140, 1, 32'h140, 1, 32'h600, 0, 32'h0);
        expect_out("mid_rst", CURR, 0, 0, 32'h0, 0, 0, 4);
        next_cycle();
        drive(0, 32'h140, 0, 0, 0, 0, 0, 0);
        expect_out("after_mid_rst", CURR, 0, 0, 32'h0, 0, 0, 0);
        next_cycle();

        drive(0, 32'h140, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10);
        expect_out("corr_wrap", CORR, 0, 1, 32'h0, 1, 32'h0, 0);
        next_cycle();
        drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        expect_out("count_after_wrap", CURR, 0, 0, 32'h0, 0, 0, 1);
        next_cycle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
